ps2_key_event_ctrl: RTL and testbench
=====================================

Name: ps2_key_event_ctrl

Overview:
Sequencer between the PS/2 byte receiver and consumers such as the seven-segment display logic and the CPU MMIO. It consumes received scancode bytes and parses Set-2 prefixes (E0 extended, F0 break) with an FSM. It suppresses typematic auto-repeat and tracks the held key and a press count. Completed key events are queued in a small FIFO drained by a valid/ready consumer.

Parameters:
DEPTH, 8, event FIFO entries (power of 2, >=2)
CNT_W, 8, width of press counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
rx_data  in  8  received scancode byte
rx_err  in  1  qualifies rx_valid: byte failed start/stop/parity check
ev_valid  out  1  FIFO non-empty; head event presented
ev_ready  in  1  consumer accepts head event when ev_valid&ev_ready
ev_code  out  8  head event scancode (final byte)
ev_ext  out  1  head event had E0 prefix
ev_break  out  1  head event is a release (F0 prefix)
key_held  out  1  a key is currently held
held_code  out  9  {ext, code} of currently held key
press_cnt  out  CNT_W  count of new (non-repeat) make events, wraps
overflow  out  1  sticky: an event was dropped on full FIFO
ovf_clr  in  1  clears overflow
fifo_level  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, any time, including mid-prefix): FSM=IDLE; FIFO empty. Outputs at reset: ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, key_held=0, held_code=0, press_cnt=0, overflow=0, fifo_level=0. ev_code/ev_ext/ev_break read 0 whenever FIFO empty.
- Bytes act only in cycles with rx_valid=1. rx_valid&rx_err: byte discarded, FSM->IDLE, nothing else changes.
- FSM states: IDLE, E0, F0, E0F0.
  - byte 0xE0: any state -> E0.
  - byte 0xF0: IDLE->F0, E0->E0F0, F0 and E0F0 stay.
  - byte 0x00 or 0xFF (keyboard error/overrun): discard, ->IDLE.
  - Any other byte is final: event {code=byte, ext=(state in E0/E0F0), break=(state in F0/E0F0)}; FSM->IDLE.
- Final-byte handling, registered in the cycle after the rx_valid cycle:
  - Make matching held_code with key_held=1 is a typematic repeat: dropped, no count, no push.
  - Any other make: push event, held_code<={ext,code}, key_held<=1, press_cnt<=press_cnt+1 (mod 2^CNT_W).
  - Break matching held_code: push event, key_held<=0, held_code unchanged.
  - Break not matching: push event, held state unchanged.
- Latency: final byte at cycle N -> ev_valid=1 and head fields valid at N+1, when the FIFO was empty.
- FIFO: circular, pointers wrap at DEPTH, head shown combinationally from storage.
  - Pop when ev_valid&ev_ready.
  - Push when full and no pop: event dropped, overflow<=1. Held/press_cnt updates still apply.
  - Push and pop in the same cycle when full: both occur, no overflow.
  - Push and pop in the same cycle when empty: no pop occurs (ev_valid=0); push lands.
- overflow: ovf_clr clears it; a drop in the same cycle as ovf_clr wins (overflow stays 1).
- ev_ready while empty: no effect, no underflow.

Decomposition:
- Shared package ps2_pkg: scancode constants (PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_ERR0=8'h00, PS2_ERR1=8'hFF), FSM state enum, and a key_event struct {code[7:0], ext, brk} (10 bits).
- Sub-module: sync_fifo (parameterised width/depth, level output, push/pop/full/empty). Instantiated with width 10. Parser FSM, repeat filter and counters stay in the top.

Test Plan:
- Make/break 1C, F0 1C -> events {1C,ext0,brk0} then {1C,0,1}; press_cnt=1; key_held 1 then 0; first ev_valid one cycle after the 1C strobe.
- Extended E0 75, E0 F0 75 -> {75,1,0}, {75,1,1}; held_code=9'h175 while held.
- Typematic 1C,1C,1C,F0 1C -> exactly 2 events; press_cnt=1.
- rx_err mid-prefix: F0 with rx_err=1, then 1C -> make event (F0 discarded); E0 then 00 then 1C -> {1C,0,0}.
- Overflow with DEPTH=8, ev_ready=0: 9 distinct makes -> level=8, overflow=1, 9th dropped, press_cnt=9. Next make with ev_ready=1 in the same cycle -> accepted, overflow stays 1 until ovf_clr.
- Reset mid-operation: assert reset after E0 with FIFO holding 3 events -> all outputs 0 immediately; following 75 -> {75,0,0}.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared scancode constants, parser states and key event record
package ps2_pkg;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_E0,
        ST_F0,
        ST_E0F0
    } ps2_state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } key_event_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular FIFO with level output; head reads zero while empty
module sync_fifo #(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // a full FIFO still accepts a push when the head leaves in the same cycle
    always_comb begin
        level   = wr_ptr - rd_ptr;
        full    = level == (AW+1)'(DEPTH);
        empty   = level == '0;
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];
    end

    // pointers carry one extra bit so full and empty are distinguishable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // storage needs no reset: the head is masked whenever the FIFO is empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl: Set-2 prefix parser, typematic filter and key event queue
module ps2_key_event_ctrl
    import ps2_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int CNT_W = 8,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             rx_err,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_break,
    output logic             key_held,
    output logic [8:0]       held_code,
    output logic [CNT_W-1:0] press_cnt,
    output logic             overflow,
    input  logic             ovf_clr,
    output logic [LW-1:0]    fifo_level
);

    ps2_state_e state;
    key_event_t ev_in, ev_head;
    logic       is_ext, is_brk, is_final, match, push, pop, full, empty, drop;

    // classify the incoming byte and decide whether it becomes a queued event
    always_comb begin
        is_ext   = state == ST_E0 || state == ST_E0F0;
        is_brk   = state == ST_F0 || state == ST_E0F0;
        is_final = rx_valid && !rx_err &&
                   !(rx_data inside {PS2_EXT, PS2_BRK, PS2_ERR0, PS2_ERR1});
        ev_in    = '{code: rx_data, ext: is_ext, brk: is_brk};
        match    = held_code == {is_ext, rx_data};
        push     = is_final && (is_brk || !(key_held && match));
        ev_valid = !empty;
        pop      = ev_valid && ev_ready;
        drop     = push && full && !pop;
        {ev_code, ev_ext, ev_break} = ev_head;
    end

    // prefix FSM plus held-key, press counter and sticky overflow registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            key_held  <= 1'b0;
            held_code <= '0;
            press_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            if (rx_valid)
                state <= rx_err             ? ST_IDLE :
                         rx_data == PS2_EXT ? ST_E0 :
                         rx_data == PS2_BRK ? (state == ST_IDLE ? ST_F0 :
                                               state == ST_E0   ? ST_E0F0 : state) :
                         ST_IDLE;
            if (push && !is_brk) begin
                held_code <= {is_ext, rx_data};
                key_held  <= 1'b1;
                press_cnt <= press_cnt + 1'b1;
            end
            if (push && is_brk && match) key_held <= 1'b0;
            overflow <= drop || (overflow && !ovf_clr);
        end
    end

    sync_fifo #(.WIDTH(10), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (ev_in),
        .pop   (pop),
        .dout  (ev_head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// tb_ps2_key_event_ctrl: directed and random stimulus against a queue-based model
module tb_ps2_key_event_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_valid = 1'b0, rx_err = 1'b0, ev_ready = 1'b0, ovf_clr = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       ev_valid, ev_ext, ev_break, key_held, overflow;
    logic [7:0] ev_code, press_cnt;
    logic [8:0] held_code;
    logic [3:0] fifo_level;

    int n_chk = 0;
    int n_fail = 0;

    bit       m_ext, m_brk, m_held, m_ovf;
    bit [8:0] m_hc;
    bit [7:0] m_cnt;
    bit [9:0] q[$];

    ps2_key_event_ctrl #(.DEPTH(8), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_err     (rx_err),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_ext     (ev_ext),
        .ev_break   (ev_break),
        .key_held   (key_held),
        .held_code  (held_code),
        .press_cnt  (press_cnt),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // compare every output against the model on each falling edge
    always @(negedge clk) begin
        bit [9:0] h;
        h = q.size() > 0 ? q[0] : 10'h0;
        chk("ev_valid", ev_valid, q.size() > 0);
        chk("ev_head", {ev_code, ev_ext, ev_break}, h);
        chk("fifo_level", fifo_level, q.size());
        chk("key_held", key_held, m_held);
        chk("held_code", held_code, m_hc);
        chk("press_cnt", press_cnt, m_cnt);
        chk("overflow", overflow, m_ovf);
    end

    // apply one cycle of inputs; the model advances on the same rising edge
    task automatic cyc(input bit v, input bit [7:0] d, input bit e, input bit r, input bit c);
        bit       nx, nb, nh, no, psh, pop, drp;
        bit [8:0] nhc;
        bit [7:0] nc;
        bit [9:0] ev;
        bit [9:0] nq[$];
        nx = m_ext; nb = m_brk; nh = m_held; no = m_ovf; nhc = m_hc; nc = m_cnt;
        nq = q; psh = 0; ev = 0;
        rx_valid = v; rx_data = d; rx_err = e; ev_ready = r; ovf_clr = c;
        pop = r && q.size() > 0;
        if (v) begin
            if (e) begin
                nx = 0; nb = 0;
            end else if (d == 8'hE0) begin
                nx = 1; nb = 0;
            end else if (d == 8'hF0) begin
                nb = 1;
            end else begin
                nx = 0; nb = 0;
                if (d != 8'h00 && d != 8'hFF) begin
                    ev = {d, m_ext, m_brk};
                    if (m_brk) begin
                        psh = 1;
                        if (m_hc == {m_ext, d}) nh = 0;
                    end else if (!(m_held && m_hc == {m_ext, d})) begin
                        psh = 1; nhc = {m_ext, d}; nh = 1; nc = m_cnt + 8'd1;
                    end
                end
            end
        end
        drp = psh && q.size() == 8 && !pop;
        if (pop) void'(nq.pop_front());
        if (psh && !drp) nq.push_back(ev);
        if (drp) no = 1;
        else if (c) no = 0;
        @(posedge clk);
        m_ext = nx; m_brk = nb; m_held = nh; m_ovf = no; m_hc = nhc; m_cnt = nc; q = nq;
        #1;
    endtask

    task automatic do_reset();
        rx_valid = 0; rx_err = 0; ev_ready = 0; ovf_clr = 0;
        reset = 1;
        m_ext = 0; m_brk = 0; m_held = 0; m_ovf = 0; m_hc = 0; m_cnt = 0;
        q.delete();
        #1;
        chk("rst_outputs", {ev_valid, ev_code, ev_ext, ev_break, key_held, held_code, press_cnt, overflow, fifo_level},
            32'h0);
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    initial begin
        bit [7:0] b;
        int       k;
        @(posedge clk);
        #1;
        do_reset();
        // make then break of 1C
        cyc(1, 8'h1C, 0, 0, 0);
        chk("lit_first_ev", {ev_valid, ev_code, ev_ext, ev_break}, {1'b1, 8'h1C, 2'b00});
        chk("lit_cnt1", {press_cnt, key_held}, {8'd1, 1'b1});
        cyc(1, 8'hF0, 0, 0, 0);
        cyc(1, 8'h1C, 0, 0, 0);
        chk("lit_break", {key_held, fifo_level}, {1'b0, 4'd2});
        cyc(0, 8'h00, 0, 1, 0);
        chk("lit_head2", {ev_code, ev_ext, ev_break}, {8'h1C, 2'b01});
        cyc(0, 8'h00, 0, 1, 0);
        // extended key
        do_reset();
        cyc(1, 8'hE0, 0, 0, 0);
        cyc(1, 8'h75, 0, 0, 0);
        chk("lit_ext_make", {held_code, ev_code, ev_ext, ev_break}, {9'h175, 8'h75, 2'b10});
        cyc(1, 8'hE0, 0, 0, 0);
        cyc(1, 8'hF0, 0, 0, 0);
        cyc(1, 8'h75, 0, 1, 0);
        chk("lit_ext_break", {ev_code, ev_ext, ev_break, key_held}, {8'h75, 2'b11, 1'b0});
        // typematic repeat
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 8'h1C, 0, 0, 0);
        cyc(1, 8'hF0, 0, 0, 0);
        cyc(1, 8'h1C, 0, 0, 0);
        chk("lit_typematic", {fifo_level, press_cnt}, {4'd2, 8'd1});
        // errors mid-prefix
        do_reset();
        cyc(1, 8'hF0, 1, 0, 0);
        cyc(1, 8'h1C, 0, 0, 0);
        chk("lit_err_f0", {ev_code, ev_ext, ev_break}, {8'h1C, 2'b00});
        do_reset();
        cyc(1, 8'hE0, 0, 0, 0);
        cyc(1, 8'h00, 0, 0, 0);
        cyc(1, 8'h1C, 0, 0, 0);
        chk("lit_err_00", {fifo_level, ev_code, ev_ext, ev_break}, {4'd1, 8'h1C, 2'b00});
        // overflow
        do_reset();
        for (int i = 0; i < 9; i++) cyc(1, 8'h10 + 8'(i), 0, 0, 0);
        chk("lit_ovf", {fifo_level, overflow, press_cnt}, {4'd8, 1'b1, 8'd9});
        cyc(1, 8'h19, 0, 1, 0);
        chk("lit_full_pp", {fifo_level, overflow, ev_code}, {4'd8, 1'b1, 8'h11});
        cyc(0, 8'h00, 0, 0, 1);
        chk("lit_ovf_clr", overflow, 0);
        // reset mid-operation
        do_reset();
        cyc(1, 8'h21, 0, 0, 0);
        cyc(1, 8'h22, 0, 0, 0);
        cyc(1, 8'h23, 0, 0, 0);
        cyc(1, 8'hE0, 0, 0, 0);
        do_reset();
        cyc(1, 8'h75, 0, 0, 0);
        chk("lit_post_rst", {ev_valid, ev_code, ev_ext, ev_break}, {1'b1, 8'h75, 2'b00});
        // random traffic
        for (int i = 0; i < 4000; i++) begin
            k = $urandom_range(0, 11);
            b = k < 3 ? 8'h1C : k < 5 ? 8'h75 : k < 6 ? 8'h23 : k < 8 ? 8'hE0 :
                k < 10 ? 8'hF0 : k < 11 ? ($urandom_range(0, 1) ? 8'hFF : 8'h00) :
                8'($urandom_range(1, 254));
            cyc($urandom_range(0, 2) != 0, b, $urandom_range(0, 15) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 20) == 0);
            if (i == 2000) do_reset();
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
